clk_switch_ctrl: RTL and testbench

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

---
 rtl/clk_switch_ctrl_if.sv | 19 +
 rtl/clk_switch_ctrl.sv | 154 +++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clk_switch_ctrl_if.sv
// Switch-request handshake bundle for clk_switch_ctrl.
// The master drives the request and the slave (controller) drives req_ready.
interface clk_switch_ctrl_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready
    );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock-mux switch sequencer: gate, switch, settle, optional lock wait.
// Optional lock check enabled by macro CLK_SW_LOCK_CHECK_EN.
module clk_switch_ctrl #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    clk_switch_ctrl_if.slave  req,
    input  logic              locked,
    output logic              mux_sel,
    output logic              clk_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef CLK_SW_LOCK_CHECK_EN
    typedef enum logic [2:0] {
        IDLE, GATE, SWITCH, SETTLE, WAIT_LOCK
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, GATE, SWITCH, SETTLE
    } state_t;
`endif

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       tgt, tgt_n;
    logic       mux_n, en_n, done_n;
    logic       ready_q;

`ifdef CLK_SW_LOCK_CHECK_EN
    logic [15:0] tcnt, tcnt_n;
    logic        lock_meta, lock_sync;
    logic        err_q, err_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            tcnt      <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_sync <= lock_meta;
            tcnt      <= tcnt_n;
            err_q     <= err_n;
        end
    end

    assign err = err_q;
`else
    logic unused_locked;
    assign unused_locked = locked;
    assign err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
        mux_n   = mux_sel;
        en_n    = clk_en;
        done_n  = 1'b0;
`ifdef CLK_SW_LOCK_CHECK_EN
        tcnt_n  = tcnt;
        err_n   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (req.req_valid) begin
                    tgt_n = req.req_sel;
`ifdef CLK_SW_LOCK_CHECK_EN
                    err_n = 1'b0;
`endif
                    if (req.req_sel == mux_sel) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = GATE;
                        en_n    = 1'b0;
                        cnt_n   = 8'(GATE_CYCLES - 1);
                    end
                end
            end
            GATE: begin
                if (cnt == 8'd0) state_n = SWITCH;
                else             cnt_n   = cnt - 8'd1;
            end
            SWITCH: begin
                // Only point where the mux select moves; clk_en is low here.
                mux_n   = tgt;
                state_n = SETTLE;
                cnt_n   = 8'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    en_n = 1'b1;
`ifdef CLK_SW_LOCK_CHECK_EN
                    state_n = WAIT_LOCK;
                    tcnt_n  = '0;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
`ifdef CLK_SW_LOCK_CHECK_EN
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tcnt == 16'(LOCK_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    tcnt_n = tcnt + 16'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= 1'b0;
            mux_sel <= 1'b0;
            clk_en  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tgt     <= tgt_n;
            mux_sel <= mux_n;
            clk_en  <= en_n;
            busy    <= (state_n != IDLE);
            done    <= done_n;
            ready_q <= (state_n == IDLE);
        end
    end

    assign req.req_ready = ready_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl against a cycle-count reference model.
// Directed sequences followed by randomized requests, resets and lock activity.
module tb_clk_switch_ctrl;
    localparam int G = 4;
    localparam int S = 8;
    localparam int T = 20;

    logic clk = 1'b0;
    logic reset;
    logic locked;
    logic mux_sel, clk_en, busy, done, err;

    clk_switch_ctrl_if rq ();

    clk_switch_ctrl #(
        .GATE_CYCLES  (G),
        .SETTLE_CYCLES(S),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (rq),
        .locked (locked),
        .mux_sel(mux_sel),
        .clk_en (clk_en),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: m_e counts cycles since a switch was accepted (0 = idle).
    int   m_e   = 0;
    logic m_sel = 1'b0;
    logic m_tgt = 1'b0;
    logic m_done = 1'b0;
    logic m_err = 1'b0;
    logic m_lk [2] = '{1'b0, 1'b0};
    logic pmux = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic s,
                         input logic r, input logic l);
        logic lsync;
        if (!r) begin
            m_e = 0; m_sel = 1'b0; m_tgt = 1'b0;
            m_done = 1'b0; m_err = 1'b0;
            m_lk[0] = 1'b0; m_lk[1] = 1'b0;
        end else begin
            lsync   = m_lk[1];
            m_lk[1] = m_lk[0];
            m_lk[0] = l;
            m_done  = 1'b0;
            if (m_e == 0) begin
                if (v) begin
                    m_err = 1'b0;
                    if (s == m_sel) m_done = 1'b1;
                    else begin m_tgt = s; m_e = 1; end
                end
            end else if (m_e < G + S + 2) begin
                m_e++;
`ifndef CLK_SW_LOCK_CHECK_EN
                if (m_e == G + S + 2) begin
                    m_e = 0; m_done = 1'b1; m_sel = m_tgt;
                end
`endif
            end else begin
                if (lsync) begin
                    m_e = 0; m_done = 1'b1; m_sel = m_tgt;
                end else if (m_e - (G + S + 2) == T - 1) begin
                    m_e = 0; m_done = 1'b1; m_sel = m_tgt; m_err = 1'b1;
                end else begin
                    m_e++;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic s,
                        input logic r, input logic l);
        logic emux;
        rq.req_valid = v;
        rq.req_sel   = s;
        reset        = r;
        locked       = l;
        @(posedge clk);
        model(v, s, r, l);
        #1;
        emux = (m_e >= G + 2) ? m_tgt : m_sel;
        chk("busy",  busy,  m_e != 0);
        chk("ready", rq.req_ready, m_e == 0);
        chk("clk_en", clk_en, !(m_e >= 1 && m_e <= G + S + 1));
        chk("mux_sel", mux_sel, emux);
        chk("done",  done,  m_done);
        chk("err",   err,   m_err);
        if (r && mux_sel !== pmux) chk("mux_gated", clk_en, 1'b0);
        pmux = mux_sel;
    endtask

    initial begin
        rq.req_valid = 1'b0;
        rq.req_sel   = 1'b0;
        reset        = 1'b0;
        locked       = 1'b1;

        // Reset, then idle.
        repeat (3) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        chk("rst_mux", mux_sel, 1'b0);
        chk("rst_en", clk_en, 1'b1);
        chk("rst_rdy", rq.req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);

        // Same-select request: immediate done, clock never gated.
        step(1, 0, 1, 1);
        chk("same_done", done, 1'b1);
        chk("same_en", clk_en, 1'b1);
        step(0, 0, 1, 1);
        chk("same_done_end", done, 1'b0);

        // Full 0->1 switch with exact cycle timeline.
        step(1, 1, 1, 1);
        for (int k = 1; k <= 13; k++) begin
            chk("sw_en_low", clk_en, 1'b0);
            if (k >= 6) chk("sw_mux1", mux_sel, 1'b1);
            else        chk("sw_mux0", mux_sel, 1'b0);
            step(0, 0, 1, 1);
        end
`ifndef CLK_SW_LOCK_CHECK_EN
        chk("sw_en14", clk_en, 1'b1);
        chk("sw_done14", done, 1'b1);
        chk("sw_rdy14", rq.req_ready, 1'b1);
`endif
        repeat (4) step(0, 0, 1, 1);

        // Back to 0, then 0->1 aborted by reset during SETTLE.
        step(1, 0, 1, 1);
        repeat (20) step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        repeat (7) step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        chk("abort_mux", mux_sel, 1'b0);
        chk("abort_en", clk_en, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);

        // Held valid with toggling select: one switch per IDLE visit.
        for (int k = 0; k < 80; k++) step(1, k[0], 1, 1);

`ifdef CLK_SW_LOCK_CHECK_EN
        // Late lock, then lock timeout, then err cleared by next request.
        repeat (20) step(0, 0, 1, 0);
        step(1, ~mux_sel, 1, 0);
        for (int k = 1; k < 30; k++) step(0, 0, 1, k >= 19);
        chk("lock_err0", err, 1'b0);
        step(1, ~mux_sel, 1, 0);
        repeat (40) step(0, 0, 1, 0);
        chk("tmo_err", err, 1'b1);
        step(1, mux_sel, 1, 0);
        chk("tmo_clr", err, 1'b0);
`endif

        // Randomized traffic with occasional resets and lock activity.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 149) != 0, $urandom_range(0, 7) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
